// File: rtl/stream_accum_if.sv
// Stream-in / result-out handshake bundle for stream_accum.
// The master side feeds beats and accepts results; the slave side is the accumulator.
interface stream_accum_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_count, m_ovf, m_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_count, m_ovf, m_valid
  );
endinterface

// File: rtl/stream_accum.sv
// Packet accumulator: sums unsigned beats up to s_last, then holds the sum,
// beat count and sticky carry flag until the downstream handshake.
module stream_accum #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  stream_accum_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH:0]   sum_s;
  logic             take_s;

  // Handshake flags are flops so neither depends combinationally on an input,
  // and both stay low through reset.
  assign take_s      = bus.s_valid & s_ready_q;
  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = acc_q;
  assign bus.m_count = cnt_q;
  assign bus.m_ovf   = ovf_q;

  // Next-state, accumulator, counter and overflow computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_s   = {1'b0, acc_q} + {1'b0, bus.s_data};

    case (state_q)
      ST_ACC: begin
        if (take_s) begin
          // A zero count marks the first beat; the counter never wraps back to 0.
          if (cnt_q == {CNT_W{1'b0}}) begin
            acc_d = bus.s_data;
            ovf_d = 1'b0;
          end else begin
            acc_d = sum_s[WIDTH-1:0];
            ovf_d = ovf_q | sum_s[WIDTH];
          end
          if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
          if (bus.s_last) begin
            state_d = ST_OUT;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          state_d = ST_ACC;
          acc_d   = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    if (rst) begin
      state_d = ST_ACC;
      acc_d   = {WIDTH{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      state_d = state_d;
    end

    s_ready_d = ~rst & (state_d == ST_ACC);
    m_valid_d = ~rst & (state_d == ST_OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    acc_q     <= acc_d;
    cnt_q     <= cnt_d;
    ovf_q     <= ovf_d;
    s_ready_q <= s_ready_d;
    m_valid_q <= m_valid_d;
  end

endmodule

// File: tb/tb_stream_accum.sv
// Directed-vector bench for stream_accum: a default-width instance plus a
// CNT_W=2 instance for counter saturation.
module tb_stream_accum;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  stream_accum_if #(.WIDTH(64), .CNT_W(16)) a_if ();
  stream_accum_if #(.WIDTH(64), .CNT_W(2))  b_if ();

  stream_accum #(.WIDTH(64), .CNT_W(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  stream_accum #(.WIDTH(64), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [63:0] data, input logic last);
    a_if.s_valid = 1'b1;
    a_if.s_data  = data;
    a_if.s_last  = last;
    step();
    a_if.s_valid = 1'b0;
    a_if.s_last  = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    a_if.s_data = 64'd0; a_if.s_valid = 1'b0; a_if.s_last = 1'b0; a_if.m_ready = 1'b0;
    b_if.s_data = 64'd0; b_if.s_valid = 1'b0; b_if.s_last = 1'b0; b_if.m_ready = 1'b1;

    step();
    step();
    check_val("rst_s_ready", {63'd0, a_if.s_ready}, 64'd0);
    check_val("rst_m_valid", {63'd0, a_if.m_valid}, 64'd0);
    check_val("rst_m_data",  a_if.m_data, 64'd0);
    check_val("rst_m_count", {48'd0, a_if.m_count}, 64'd0);
    check_val("rst_m_ovf",   {63'd0, a_if.m_ovf}, 64'd0);

    rst = 1'b0;
    step();
    check_val("rel_s_ready", {63'd0, a_if.s_ready}, 64'd1);

    // Beats with s_valid low must be ignored even with s_last set.
    a_if.s_data = 64'hDEAD; a_if.s_last = 1'b1;
    step();
    step();
    a_if.s_last = 1'b0;
    check_val("novalid_m_valid", {63'd0, a_if.m_valid}, 64'd0);

    // 1+2+3+4 with downstream always ready.
    a_if.m_ready = 1'b1;
    send_a(64'd1, 1'b0);
    send_a(64'd2, 1'b0);
    send_a(64'd3, 1'b0);
    check_val("sum4_pre_valid", {63'd0, a_if.m_valid}, 64'd0);
    send_a(64'd4, 1'b1);
    check_val("sum4_m_valid", {63'd0, a_if.m_valid}, 64'd1);
    check_val("sum4_m_data",  a_if.m_data, 64'd10);
    check_val("sum4_m_count", {48'd0, a_if.m_count}, 64'd4);
    check_val("sum4_m_ovf",   {63'd0, a_if.m_ovf}, 64'd0);
    check_val("sum4_s_ready", {63'd0, a_if.s_ready}, 64'd0);
    step();
    check_val("sum4_done_valid", {63'd0, a_if.m_valid}, 64'd0);
    check_val("sum4_done_ready", {63'd0, a_if.s_ready}, 64'd1);

    // Carry out of the top bit.
    send_a(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_a(64'h2, 1'b1);
    check_val("ovf_m_data",  a_if.m_data, 64'd1);
    check_val("ovf_m_count", {48'd0, a_if.m_count}, 64'd2);
    check_val("ovf_m_ovf",   {63'd0, a_if.m_ovf}, 64'd1);
    step();

    // Result held under backpressure while upstream keeps offering a beat.
    a_if.m_ready = 1'b0;
    send_a(64'h10, 1'b0);
    send_a(64'h20, 1'b1);
    a_if.s_valid = 1'b1; a_if.s_data = 64'h99; a_if.s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("hold%0d_s_ready", i), {63'd0, a_if.s_ready}, 64'd0);
      check_val($sformatf("hold%0d_m_valid", i), {63'd0, a_if.m_valid}, 64'd1);
      check_val($sformatf("hold%0d_m_data", i),  a_if.m_data, 64'h30);
    end
    a_if.m_ready = 1'b1;
    check_val("hs_cycle_s_ready", {63'd0, a_if.s_ready}, 64'd0);
    step();
    a_if.s_valid = 1'b0;
    check_val("after_hs_s_ready", {63'd0, a_if.s_ready}, 64'd1);
    check_val("after_hs_m_valid", {63'd0, a_if.m_valid}, 64'd0);

    // Single-beat packet; count of 1 also shows 0x99 was not taken at the handshake.
    send_a(64'h55, 1'b1);
    check_val("single_m_data",  a_if.m_data, 64'h55);
    check_val("single_m_count", {48'd0, a_if.m_count}, 64'd1);
    check_val("single_m_ovf",   {63'd0, a_if.m_ovf}, 64'd0);
    step();

    // Reset mid-packet discards the partial sum.
    send_a(64'd5, 1'b0);
    send_a(64'd6, 1'b0);
    rst = 1'b1;
    step();
    check_val("midrst_s_ready", {63'd0, a_if.s_ready}, 64'd0);
    check_val("midrst_m_data",  a_if.m_data, 64'd0);
    check_val("midrst_m_count", {48'd0, a_if.m_count}, 64'd0);
    rst = 1'b0;
    step();
    check_val("midrst_rel_ready", {63'd0, a_if.s_ready}, 64'd1);
    send_a(64'd7, 1'b1);
    check_val("postrst_m_valid", {63'd0, a_if.m_valid}, 64'd1);
    check_val("postrst_m_data",  a_if.m_data, 64'd7);
    check_val("postrst_m_count", {48'd0, a_if.m_count}, 64'd1);
    step();

    // Reset while a result is pending drops it.
    a_if.m_ready = 1'b0;
    send_a(64'd8, 1'b1);
    rst = 1'b1;
    step();
    check_val("outrst_m_valid", {63'd0, a_if.m_valid}, 64'd0);
    check_val("outrst_m_data",  a_if.m_data, 64'd0);
    rst = 1'b0;
    a_if.m_ready = 1'b1;
    step();
    check_val("outrst_rel_ready", {63'd0, a_if.s_ready}, 64'd1);

    // Counter saturation on the narrow-counter instance.
    for (int i = 0; i < 6; i++) begin
      b_if.s_valid = 1'b1;
      b_if.s_data  = 64'd1;
      b_if.s_last  = (i == 5) ? 1'b1 : 1'b0;
      step();
    end
    b_if.s_valid = 1'b0;
    b_if.s_last  = 1'b0;
    check_val("sat_m_valid", {63'd0, b_if.m_valid}, 64'd1);
    check_val("sat_m_count", {62'd0, b_if.m_count}, 64'd3);
    check_val("sat_m_data",  b_if.m_data, 64'd6);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
